// File: rtl/tmr_counter_channel.sv
// One 8-bit timer channel: prescaler, count-source select, TCNT with clear modes,
// TCORA/TCORB constant registers, and registered compare-match / overflow pulses.
module tmr_counter_channel #(
  parameter int unsigned BIT_WIDTH            = 8,
  parameter int unsigned CLK_SELECT_BIT_WIDTH = 3,
  parameter int unsigned PRESCALE_WIDTH       = 13
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [CLK_SELECT_BIT_WIDTH-1:0] clock_select,
  input  logic [1:0]                      cclr,
  input  logic                            counter_clear,
  input  logic                            ext_clk,
  input  logic                            cascade_in,
  input  logic                            wr_en,
  input  logic [1:0]                      wr_addr,
  input  logic [BIT_WIDTH-1:0]            wr_data,
  output logic [BIT_WIDTH-1:0]            tcnt,
  output logic [BIT_WIDTH-1:0]            tcora,
  output logic [BIT_WIDTH-1:0]            tcorb,
  output logic                            CompareMatchA,
  output logic                            CompareMatchB,
  output logic                            Overflow
);

  logic [PRESCALE_WIDTH-1:0] r_prescaler;
  logic                      r_ext_s1, r_ext_s2, r_ext_hist;
  logic [BIT_WIDTH-1:0]      r_tcnt, r_tcora, r_tcorb;
  logic                      r_eqa_q, r_eqb_q, r_tcnt_written_q;
  logic                      r_cmp_a, r_cmp_b, r_ovf;

  logic                      w_tick, w_clr, w_eqa, w_eqb;
  logic                      w_wr_tcnt, w_wr_tcora, w_wr_tcorb;
  logic                      w_ext_rise, w_ext_fall;
  logic [BIT_WIDTH-1:0]      w_tcnt_d;

  assign w_wr_tcnt  = wr_en && (wr_addr == 2'b00);
  assign w_wr_tcora = wr_en && (wr_addr == 2'b01);
  assign w_wr_tcorb = wr_en && (wr_addr == 2'b10);

  assign w_ext_rise = r_ext_s2 && !r_ext_hist;
  assign w_ext_fall = !r_ext_s2 && r_ext_hist;

  assign w_eqa = (r_tcnt == r_tcora);
  assign w_eqb = (r_tcnt == r_tcorb);

  always_comb begin
    w_tick = 1'b0;
    case (clock_select)
      3'd1:    w_tick = &r_prescaler[2:0];
      3'd2:    w_tick = &r_prescaler[5:0];
      3'd3:    w_tick = &r_prescaler;
      3'd4:    w_tick = cascade_in;
      3'd5:    w_tick = w_ext_rise;
      3'd6:    w_tick = w_ext_fall;
      3'd7:    w_tick = w_ext_rise || w_ext_fall;
      default: w_tick = 1'b0;
    endcase
  end

  always_comb begin
    w_clr = 1'b0;
    case (cclr)
      2'b01:   w_clr = w_eqa;
      2'b10:   w_clr = w_eqb;
      2'b11:   w_clr = counter_clear;
      default: w_clr = 1'b0;
    endcase
  end

  // CPU write beats clear, clear beats increment; clears only land on a tick.
  always_comb begin
    w_tcnt_d = r_tcnt;
    if (w_wr_tcnt) begin
      w_tcnt_d = wr_data;
    end else if (w_clr && w_tick) begin
      w_tcnt_d = '0;
    end else if (w_tick) begin
      w_tcnt_d = r_tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prescaler      <= '0;
      r_ext_s1         <= 1'b0;
      r_ext_s2         <= 1'b0;
      r_ext_hist       <= 1'b0;
      r_tcnt           <= '0;
      r_tcora          <= '1;
      r_tcorb          <= '1;
      r_eqa_q          <= 1'b0;
      r_eqb_q          <= 1'b0;
      r_tcnt_written_q <= 1'b0;
      r_cmp_a          <= 1'b0;
      r_cmp_b          <= 1'b0;
      r_ovf            <= 1'b0;
    end else begin
      r_prescaler      <= r_prescaler + 1'b1;
      r_ext_s1         <= ext_clk;
      r_ext_s2         <= r_ext_s1;
      r_ext_hist       <= r_ext_s2;
      r_tcnt           <= w_tcnt_d;
      if (w_wr_tcora) r_tcora <= wr_data;
      if (w_wr_tcorb) r_tcorb <= wr_data;
      r_eqa_q          <= w_eqa;
      r_eqb_q          <= w_eqb;
      r_tcnt_written_q <= w_wr_tcnt;
      // A freshly written TCNT never raises a match, even if it equals TCORx.
      r_cmp_a          <= w_eqa && !r_eqa_q && !r_tcnt_written_q;
      r_cmp_b          <= w_eqb && !r_eqb_q && !r_tcnt_written_q;
      r_ovf            <= w_tick && (&r_tcnt) && !w_clr && !w_wr_tcnt;
    end
  end

  assign tcnt          = r_tcnt;
  assign tcora         = r_tcora;
  assign tcorb         = r_tcorb;
  assign CompareMatchA = r_cmp_a;
  assign CompareMatchB = r_cmp_b;
  assign Overflow      = r_ovf;

endmodule

// File: tb/tb_tmr_counter_channel.sv
// Directed bench for tmr_counter_channel: stimulus and checks on the falling clock edge.
module tb_tmr_counter_channel;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] clock_select;
  logic [1:0] cclr;
  logic       counter_clear;
  logic       ext_clk;
  logic       cascade_in;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] tcnt, tcora, tcorb;
  logic       CompareMatchA, CompareMatchB, Overflow;

  int n_checks = 0;
  int n_errors = 0;
  int cnt_a, cnt_b, cnt_ovf;
  logic [7:0] max_tcnt;

  tmr_counter_channel dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clock_select (clock_select),
    .cclr         (cclr),
    .counter_clear(counter_clear),
    .ext_clk      (ext_clk),
    .cascade_in   (cascade_in),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .tcnt         (tcnt),
    .tcora        (tcora),
    .tcorb        (tcorb),
    .CompareMatchA(CompareMatchA),
    .CompareMatchB(CompareMatchB),
    .Overflow     (Overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [1:0] addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic cascade_pulse();
    cascade_in = 1'b1;
    @(negedge clk);
    cascade_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clock_select = 3'd1; cclr = 2'b00; counter_clear = 1'b0;
    ext_clk = 1'b0; cascade_in = 1'b0; wr_en = 1'b0; wr_addr = 2'b00; wr_data = 8'h00;
    step(2);
    check("reset_tcnt", tcnt, 8'h00);
    check("reset_tcora", tcora, 8'hFF);
    check("reset_tcorb", tcorb, 8'hFF);
    check("reset_pulses", {CompareMatchA, CompareMatchB, Overflow}, 3'b000);

    // 1: clk/8 free run, wrap after 2048 clocks
    rst_n = 1'b1;
    step(7);
    check("div8_before_tick", tcnt, 8'h00);
    step(1);
    check("div8_first_tick", tcnt, 8'h01);
    step(2039);
    check("div8_at_ff", tcnt, 8'hFF);
    check("div8_no_ovf_yet", Overflow, 1'b0);
    step(1);
    check("div8_wrap", tcnt, 8'h00);
    check("div8_ovf_pulse", Overflow, 1'b1);
    step(1);
    check("div8_ovf_one_clk", Overflow, 1'b0);

    // 2: clear on match A with TCORA=5, 12 ticks in 96 clocks
    clock_select = 3'd0;
    cpu_write(2'b01, 8'h05);
    cpu_write(2'b00, 8'h00);
    cclr = 2'b01;
    clock_select = 3'd1;
    cnt_a = 0; cnt_ovf = 0; max_tcnt = 8'h00;
    for (int i = 0; i < 96; i++) begin
      step(1);
      if (tcnt > max_tcnt) max_tcnt = tcnt;
      if (Overflow) cnt_ovf++;
      if (CompareMatchA) begin
        cnt_a++;
        check("cma_at_tcora", tcnt, 8'h05);
      end
    end
    check("cma_count", cnt_a, 2);
    check("cma_no_ovf", cnt_ovf, 0);
    check("cma_max_tcnt", max_tcnt, 8'h05);
    check("cma_final_tcnt", tcnt, 8'h00);

    // 3: match B on TCORB write, none on TCNT writes
    clock_select = 3'd0;
    cclr = 2'b00;
    cpu_write(2'b00, 8'h10);
    cpu_write(2'b10, 8'h10);
    step(1);
    check("cmb_after_tcorb_wr", CompareMatchB, 1'b1);
    cnt_b = 1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (CompareMatchB) cnt_b++;
    end
    check("cmb_single_pulse", cnt_b, 1);
    cpu_write(2'b00, 8'h0F);
    cpu_write(2'b00, 8'h10);
    cnt_b = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (CompareMatchB) cnt_b++;
    end
    check("cmb_no_pulse_on_tcnt_wr", cnt_b, 0);

    // 4: external clock, falling edges then both edges
    cpu_write(2'b00, 8'h00);
    ext_clk = 1'b1;
    step(4);
    clock_select = 3'd6;
    for (int i = 0; i < 4; i++) begin
      ext_clk = 1'b0;
      step(2);
      check("ext_fall_latency", tcnt, i);
      step(1);
      check("ext_fall_tick", tcnt, i + 1);
      step(2);
      ext_clk = 1'b1;
      step(5);
    end
    check("ext_fall_total", tcnt, 8'h04);
    clock_select = 3'd0;
    cpu_write(2'b00, 8'h00);
    clock_select = 3'd7;
    for (int i = 0; i < 4; i++) begin
      ext_clk = 1'b0;
      step(3);
      check("ext_both_fall", tcnt, 2 * i + 1);
      step(2);
      ext_clk = 1'b1;
      step(3);
      check("ext_both_rise", tcnt, 2 * i + 2);
      step(2);
    end
    check("ext_both_total", tcnt, 8'h08);

    // 5: cascade input, then asynchronous reset mid-cycle
    clock_select = 3'd0;
    cpu_write(2'b01, 8'h33);
    cpu_write(2'b10, 8'h44);
    cpu_write(2'b00, 8'h00);
    clock_select = 3'd4;
    for (int i = 0; i < 3; i++) begin
      cascade_pulse();
      step(2);
    end
    check("cascade_count", tcnt, 8'h03);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_tcnt", tcnt, 8'h00);
    check("async_rst_tcora", tcora, 8'hFF);
    check("async_rst_tcorb", tcorb, 8'hFF);

    // 6: cclr=11 holds at zero; a TCNT write wins over clear+tick
    @(negedge clk);
    cclr = 2'b11; counter_clear = 1'b1; clock_select = 3'd1;
    rst_n = 1'b1;
    step(40);
    check("cclr11_hold_zero", tcnt, 8'h00);
    step(7);
    wr_en = 1'b1; wr_addr = 2'b00; wr_data = 8'h80;
    step(1);
    wr_en = 1'b0;
    check("wr_beats_clr_tick", tcnt, 8'h80);
    step(7);
    check("cclr11_waits_tick", tcnt, 8'h80);
    step(1);
    check("cclr11_clear_on_tick", tcnt, 8'h00);

    // 7: clear at 0xFF via TCORA suppresses overflow; A and B match together
    counter_clear = 1'b0;
    clock_select = 3'd0;
    cclr = 2'b01;
    cpu_write(2'b00, 8'hFE);
    clock_select = 3'd4;
    cascade_pulse();
    check("clr_ff_reach", tcnt, 8'hFF);
    step(1);
    check("both_match_a", CompareMatchA, 1'b1);
    check("both_match_b", CompareMatchB, 1'b1);
    step(1);
    cascade_pulse();
    check("clr_ff_to_zero", tcnt, 8'h00);
    check("clr_ff_no_ovf", Overflow, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tmr_counter_channel.md
Name: tmr_counter_channel

Overview:
One 8-bit timer channel datapath: prescaler, count-source selection, TCNT counter, TCORA/TCORB constant registers and comparators.
It feeds ControlLogic with CompareMatchA/B and Overflow pulses, and consumes its clock_select and CounterClear outputs.
Two instances are used, one for channel 0 and one for channel 1. The cascade_in input of each instance is tied to the other instance's overflow.

Parameters:
BIT_WIDTH, 8, counter and register width
CLK_SELECT_BIT_WIDTH, 3, width of clock_select
PRESCALE_WIDTH, 13, free-running prescaler width (covers clk/8192)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
clock_select  input  CLK_SELECT_BIT_WIDTH  count-source select (CKS2:0)
cclr  input  2  counter clear mode (CCLR1:0)
counter_clear  input  1  external clear request from ControlLogic, level
ext_clk  input  1  external count pin, asynchronous to clk
cascade_in  input  1  one-clk pulse from the neighbour channel's overflow
wr_en  input  1  CPU register write strobe
wr_addr  input  2  write target: 00 TCNT, 01 TCORA, 10 TCORB, 11 ignored
wr_data  input  BIT_WIDTH  write data
tcnt  output  BIT_WIDTH  counter value
tcora  output  BIT_WIDTH  constant register A
tcorb  output  BIT_WIDTH  constant register B
CompareMatchA  output  1  one-clk pulse on TCNT==TCORA
CompareMatchB  output  1  one-clk pulse on TCNT==TCORB
Overflow  output  1  one-clk pulse on FF->00 wrap

Behaviour:
- Reset (rst_n low, asynchronous) sets:
  - tcnt=0x00, tcora=0xFF, tcorb=0xFF
  - prescaler=0
  - ext sync/edge flops=0
  - all pulse outputs=0 and the equality-history flops=0
- Releasing reset mid-count restarts everything from these values.
- Prescaler: free-running, increments every clk, wraps at 2^PRESCALE_WIDTH.
- Count tick (one clk wide), selected by clock_select:
  - 000: no tick, counter stopped
  - 001: tick when prescaler[2:0]==7 (clk/8)
  - 010: tick when prescaler[5:0]==63 (clk/64)
  - 011: tick when prescaler[12:0]==8191 (clk/8192)
  - 100: tick = cascade_in
  - 101: rising edge of ext_clk
  - 110: falling edge of ext_clk
  - 111: both edges of ext_clk
- ext_clk path:
  - Two-flop synchronizer, then one edge-history flop.
  - Edge detect compares the synchronized value with the history flop.
  - A pin edge produces its tick on the 3rd clk edge after the pin transition.
  - A pin pulse shorter than 2 clk may be lost (documented limitation).
- Clear condition `clr`:
  - cclr=00: never
  - cclr=01: eqA (tcnt==tcora)
  - cclr=10: eqB (tcnt==tcorb)
  - cclr=11: counter_clear
- tcnt next-state, priority high to low:
  1. wr_en && wr_addr==00: tcnt <= wr_data
  2. clr && tick: tcnt <= 0
  3. tick: tcnt <= tcnt+1, modulo 2^BIT_WIDTH
  4. otherwise hold
- Clear mode cclr=11 clears on the next tick while counter_clear is high. It is not an immediate clear.
- Compare match:
  - eqA/eqB are combinational on the current registers.
  - CompareMatchA <= eqA && !eqA_q && !tcnt_written_q; CompareMatchB likewise. eqX_q is eqX delayed one clk.
  - Result: one pulse per entry into equality, asserted 1 clk after equality begins. The pulse is not repeated while the counter dwells.
  - tcnt_written_q is set for 1 clk after a TCNT write, so writing a value equal to TCORx produces no match pulse.
  - Writing TCORx to equal the current tcnt does produce a pulse (1 clk later).
- Overflow:
  - Overflow <= tick && tcnt==all-ones && !clr && !TCNT-write.
  - The pulse is high in the cycle tcnt reads 0x00.
  - A clear at 0xFF (e.g. TCORA=0xFF with cclr=01) suppresses Overflow.
- Simultaneous events:
  - eqA and eqB can pulse in the same cycle.
  - A CPU write to TCNT wins over tick and clear.
  - A write to TCORx in the same cycle as a tick takes effect on the register, and the comparison uses the new value from the next cycle.
- Changing clock_select mid-count takes effect on the next clk. The prescaler is not reset, so the first tick of a new rate may come early.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset then clock_select=001, cclr=00 -> tcnt increments every 8 clk. After 2048 clk, tcnt wraps 0xFF->0x00 with Overflow high for exactly 1 clk.
2. TCORA=0x05, cclr=01, clock_select=001 -> CompareMatchA pulses once when tcnt=0x05. tcnt returns to 0x00 on the next tick (period 6 ticks). Overflow never fires.
3. TCORB=0x10, cclr=00, hold tcnt at 0x10 with clock_select=000 -> exactly one CompareMatchB pulse. Then write TCNT=0x10 -> no pulse.
4. clock_select=110, drive ext_clk with 4 falling edges spaced 10 clk apart -> tcnt=4. Each increment lands 3 clk after its edge. Same pattern with 111 -> tcnt=8.
5. clock_select=100, cascade_in pulsed 3 times -> tcnt=3. Assert rst_n low mid-sequence -> tcnt=0x00 and tcora=tcorb=0xFF immediately, without waiting for clk.
6. cclr=11, counter_clear high, clock_select=001 -> tcnt stays 0x00. Same-cycle TCNT write 0x80 with tick -> tcnt=0x80.
